// File: rtl/uart_read_arbiter.sv
// Two-requester read arbiter that packs up to four bytes from the UART byte FIFO into one response word.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req[0] has fixed priority.
module uart_read_arbiter #(
    parameter logic [7:0] PAD_BYTE = 8'hFF
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [7:0]  fifo_rd_data,
    input  logic [4:0]  fifo_count,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_count
);

    // state | meaning
    // IDLE  | waiting for any req bit, no grant held
    // POP   | popping n bytes, one per edge, into word lanes 3 down to 4-n
    // DONE  | one-cycle response pulse, grant released on the next edge
    typedef enum logic [1:0] {
        IDLE,
        POP,
        DONE
    } state_t;

    state_t      state;
    logic [2:0]  n_lat;
    logic [2:0]  left;
    logic [1:0]  lane;
    logic [31:0] word;
    logic        id_lat;

    logic        winner;
    logic [2:0]  n_next;
    logic [7:0]  pop_byte;
    logic [31:0] word_next;

    // counts above 16 collapse to 4 here as well, so no separate clamp is needed
    always_comb begin
        if (fifo_count >= 5'd4) begin
            n_next = 3'd4;
        end else begin
            n_next = fifo_count[2:0];
        end
    end

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else begin
            winner = ~req[0];
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && req != 2'b00) begin
            last_gnt <= winner;
        end
    end
`else
    assign winner = ~req[0];
`endif

    assign fifo_rd_en = (state == POP) && !fifo_empty;

    // an empty FIFO mid-transaction still consumes a lane, filled with padding
    assign pop_byte = fifo_empty ? PAD_BYTE : fifo_rd_data;

    always_comb begin
        word_next = word;
        word_next[{lane, 3'b000} +: 8] = pop_byte;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'hFFFF_FFFF;
            rsp_count <= 3'd0;
            n_lat     <= 3'd0;
            left      <= 3'd0;
            lane      <= 2'd3;
            word      <= {4{PAD_BYTE}};
            id_lat    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt    <= winner ? 2'b10 : 2'b01;
                        id_lat <= winner;
                        n_lat  <= n_next;
                        left   <= n_next;
                        lane   <= 2'd3;
                        word   <= {4{PAD_BYTE}};
                        busy   <= 1'b1;
                        if (n_next == 3'd0) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_id    <= winner;
                            rsp_data  <= {4{PAD_BYTE}};
                            rsp_count <= 3'd0;
                        end else begin
                            state <= POP;
                        end
                    end
                end
                POP: begin
                    word <= word_next;
                    lane <= lane - 2'd1;
                    left <= left - 3'd1;
                    if (left == 3'd1) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_lat;
                        rsp_data  <= word_next;
                        rsp_count <= n_lat;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    gnt       <= 2'b00;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_read_arbiter.sv
// Bench for uart_read_arbiter: queue-based FIFO, transaction-level reference model, directed transactions.
module tb_uart_read_arbiter;

    localparam logic [7:0] PAD = 8'hFF;
`ifdef UART_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  fifo_rd_data;
    logic [4:0]  fifo_count;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [1:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_count;

    uart_read_arbiter #(.PAD_BYTE(PAD)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .req         (req),
        .fifo_rd_data(fifo_rd_data),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .gnt         (gnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_count   (rsp_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [7:0] fq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    bit pop_now = 1'b0;

    // reference model: one transaction at a time, timed in cycles since acceptance
    bit          m_active;
    int          m_t;
    int          m_n;
    logic        m_id;
    logic        m_last;
    logic [31:0] m_word;
    logic [31:0] e_data;
    logic [2:0]  e_count;
    logic        e_id;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic sync_fifo();
        fifo_count   = (fq.size() > 31) ? 5'd31 : 5'(fq.size());
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic step();
        @(negedge clk_100MHz);
        #1;
    endtask

    always @(posedge clk_100MHz) pop_now = fifo_rd_en;

    always @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_n      = 0;
            m_id     = 1'b0;
            m_last   = 1'b1;
            m_word   = 32'hFFFF_FFFF;
            e_data   = 32'hFFFF_FFFF;
            e_count  = 3'd0;
            e_id     = 1'b0;
        end else if (m_active) begin
            if (m_t == m_n + 1) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t == m_n + 1) begin
                    e_data  = m_word;
                    e_count = 3'(m_n);
                    e_id    = m_id;
                end
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_id = RR ? ~m_last : 1'b0;
            else              m_id = req[1];
            m_last = m_id;
            m_n    = (fifo_count > 5'd4) ? 4 : int'(fifo_count);
            m_word = {4{PAD}};
            for (int i = 0; i < m_n; i++) begin
                if (i < fq.size()) m_word[31 - 8*i -: 8] = fq[i];
            end
            m_active = 1'b1;
            m_t      = 1;
            if (m_n == 0) begin
                e_data  = m_word;
                e_count = 3'd0;
                e_id    = m_id;
            end
        end
    end

    always @(negedge clk_100MHz) begin
        cyc++;
        chk("gnt", 32'(gnt), m_active ? (m_id ? 32'd2 : 32'd1) : 32'd0);
        chk("busy", 32'(busy), 32'(m_active));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_active && m_t == m_n + 1));
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(m_active && m_t <= m_n && !fifo_empty));
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_count", 32'(rsp_count), 32'(e_count));
        if (fifo_rd_en) rd_cnt++;
        if (pop_now) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pop_now = 1'b0;
        end
        sync_fifo();
    end

    task automatic run_txn(input logic [1:0] r, output int lat, output logic [31:0] d,
                           output logic [2:0] c, output logic id);
        int start;
        bit got;
        got   = 1'b0;
        rd_cnt = 0;
        start = cyc;
        req   = r;
        lat = 0; d = '0; c = '0; id = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (rsp_valid) begin
                got = 1'b1;
                lat = cyc - start;
                d   = rsp_data;
                c   = rsp_count;
                id  = rsp_id;
            end
        end
        req = 2'b00;
        chk("rsp_timeout", 32'(got), 32'd1);
        step();
    endtask

    int          lat;
    logic [31:0] d;
    logic [2:0]  c;
    logic        id;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sync_fifo();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_rsp_data", rsp_data, 32'hFFFF_FFFF);
        chk("reset_rsp_count", 32'(rsp_count), 32'd0);

        // six bytes queued, only four taken
        fq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        sync_fifo();
        run_txn(2'b01, lat, d, c, id);
        chk("t1_data", d, 32'h1112_1314);
        chk("t1_count", 32'(c), 32'd4);
        chk("t1_id", 32'(id), 32'd0);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_pops", 32'(rd_cnt), 32'd4);
        chk("t1_left_in_fifo", 32'(fq.size()), 32'd2);

        fq.delete();
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        sync_fifo();
        run_txn(2'b10, lat, d, c, id);
        chk("t2_data", d, 32'hA1A2_FFFF);
        chk("t2_count", 32'(c), 32'd2);
        chk("t2_id", 32'(id), 32'd1);
        chk("t2_pops", 32'(rd_cnt), 32'd2);

        fq.delete();
        sync_fifo();
        run_txn(2'b01, lat, d, c, id);
        chk("t3_data", d, 32'hFFFF_FFFF);
        chk("t3_count", 32'(c), 32'd0);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_pops", 32'(rd_cnt), 32'd0);

        // both requesters held high across three transactions from a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                step();
                if (rsp_valid) begin
                    got = 1'b1;
                    chk("rr_id", 32'(rsp_id), 32'(RR && k == 1));
                end
            end
            chk("rr_timeout", 32'(got), 32'd1);
        end
        req = 2'b00;
        step();
        step();

        // reset during the second pop of a four-byte transaction
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        fq = '{8'h21, 8'h22, 8'h23, 8'h24};
        sync_fifo();
        req = 2'b01;
        step();
        step();
        chk("t4_second_pop", 32'(fifo_rd_en), 32'd1);
        reset = 1'b1;
        req   = 2'b00;
        #1;
        chk("t4_gnt", 32'(gnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t4_valid", 32'(rsp_valid), 32'd0);
        chk("t4_data", rsp_data, 32'hFFFF_FFFF);
        chk("t4_count", 32'(rsp_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        run_txn(2'b10, lat, d, c, id);
        chk("t5_data", d, 32'h2223_24FF);
        chk("t5_count", 32'(c), 32'd3);
        chk("t5_id", 32'(id), 32'd1);
        chk("t5_latency", 32'(lat), 32'd4);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
